// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl: three-spot parking lot controller with debounced sensors,
// entrance/exit gate FSMs and an occupancy counter (0..3).
// Ports:
//   CLOCK_50          - single clock for all state
//   reset_n           - asynchronous active-low reset
//   presence_spot     - raw spot sensors, 1 = car in spot i
//   presence_entrance - raw sensor, 1 = car at entrance gate
//   presence_exit     - raw sensor, 1 = car at exit gate
//   led_spot          - registered debounced spot occupancy
//   led_full          - registered (occupancy == 3)
//   open_entrance     - entrance gate open
//   open_exit         - exit gate open
//   occupancy         - cars currently inside the lot
module parking_lot_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 16,
    parameter int unsigned GATE_HOLD_CYCLES = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [2:0] presence_spot,
    input  logic       presence_entrance,
    input  logic       presence_exit,
    output logic [2:0] led_spot,
    output logic       led_full,
    output logic       open_entrance,
    output logic       open_exit,
    output logic [1:0] occupancy
);
    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0] HOLD_LOAD = 26'(GATE_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OPEN, HOLD} gate_e;

    logic [4:0]  raw, sync1_q, sync2_q, deb;
    gate_e       ent_q, ent_d, ext_q, ext_d;
    logic [25:0] ent_tmr_q, ent_tmr_d, ext_tmr_q, ext_tmr_d;
    logic [1:0]  occ_q, occ_d;
    logic [2:0]  led_q;
    logic        full_q, oe_q, ox_q;
    logic        deb_ent, deb_ext, not_full, inc, dec;

    assign raw = {presence_exit, presence_entrance, presence_spot};

    // Debounced value follows the synchronized value only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles; agreement clears the count.
    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [15:0] cnt_q;
        logic        deb_q;
        logic        diff;
        assign diff   = sync2_q[i] != deb_q;
        assign deb[i] = deb_q;
        always_ff @(posedge CLOCK_50 or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else begin
                cnt_q <= (!diff || cnt_q == DB_LAST) ? '0 : cnt_q + 16'd1;
                deb_q <= (diff && cnt_q == DB_LAST) ? sync2_q[i] : deb_q;
            end
        end
    end

    assign deb_ent  = deb[3];
    assign deb_ext  = deb[4];
    assign not_full = occ_q != 2'd3;

    always_comb begin
        ent_d     = ent_q;
        ent_tmr_d = ent_tmr_q;
        ext_d     = ext_q;
        ext_tmr_d = ext_tmr_q;
        case (ent_q)
            IDLE: if (deb_ent && not_full) ent_d = OPEN;
            OPEN: if (!deb_ent) begin
                ent_d     = HOLD;
                ent_tmr_d = HOLD_LOAD;
            end
            // A new car arriving during hold reopens unless the lot is full.
            HOLD: if (deb_ent && not_full) ent_d = OPEN;
                  else if (ent_tmr_q == '0) ent_d = IDLE;
                  else ent_tmr_d = ent_tmr_q - 26'd1;
            default: ent_d = IDLE;
        endcase
        case (ext_q)
            IDLE: if (deb_ext) ext_d = OPEN;
            OPEN: if (!deb_ext) begin
                ext_d     = HOLD;
                ext_tmr_d = HOLD_LOAD;
            end
            HOLD: if (deb_ext) ext_d = OPEN;
                  else if (ext_tmr_q == '0) ext_d = IDLE;
                  else ext_tmr_d = ext_tmr_q - 26'd1;
            default: ext_d = IDLE;
        endcase
    end

    // A car is counted when it clears the sensor of an open gate; a
    // simultaneous entry and exit cancel, and decrement saturates at 0.
    assign inc   = ent_q == OPEN && !deb_ent;
    assign dec   = ext_q == OPEN && !deb_ext && occ_q != 2'd0;
    assign occ_d = (inc == dec) ? occ_q : inc ? occ_q + 2'd1 : occ_q - 2'd1;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            ent_q     <= IDLE;
            ext_q     <= IDLE;
            ent_tmr_q <= '0;
            ext_tmr_q <= '0;
            occ_q     <= '0;
            led_q     <= '0;
            full_q    <= 1'b0;
            oe_q      <= 1'b0;
            ox_q      <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            ent_q     <= ent_d;
            ext_q     <= ext_d;
            ent_tmr_q <= ent_tmr_d;
            ext_tmr_q <= ext_tmr_d;
            occ_q     <= occ_d;
            led_q     <= deb[2:0];
            full_q    <= occ_q == 2'd3;
            oe_q      <= ent_d != IDLE;
            ox_q      <= ext_d != IDLE;
        end
    end

    assign led_spot      = led_q;
    assign led_full      = full_q;
    assign open_entrance = oe_q;
    assign open_exit     = ox_q;
    assign occupancy     = occ_q;
endmodule

// File: tb/tb_parking_lot_ctrl.sv
// tb_parking_lot_ctrl: directed scenarios with a cycle-level reference model.
module tb_parking_lot_ctrl;
    localparam int D = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] presence_spot = '0;
    logic       presence_entrance = 1'b0;
    logic       presence_exit = 1'b0;
    logic [2:0] led_spot;
    logic       led_full, open_entrance, open_exit;
    logic [1:0] occupancy;

    int tests = 0;
    int fails = 0;

    parking_lot_ctrl #(.DEBOUNCE_CYCLES(D), .GATE_HOLD_CYCLES(G)) dut (
        .CLOCK_50(clk),
        .reset_n(reset_n),
        .presence_spot(presence_spot),
        .presence_entrance(presence_entrance),
        .presence_exit(presence_exit),
        .led_spot(led_spot),
        .led_full(led_full),
        .open_entrance(open_entrance),
        .open_exit(open_exit),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: sensors are sampled twice, a debounced value changes once
    // the sampled value has held a new level for D cycles; gates are tracked as
    // phase (0 closed, 1 car under gate, 2 holding) plus cycles left to hold.
    logic [4:0] raw, m_s1, m_s2, m_last, m_deb, n_last, n_deb;
    int         m_run [5];
    int         n_run [5];
    int         m_occ, n_occ, e_ph, n_eph, e_left, n_eleft, x_ph, n_xph, x_left, n_xleft, inc, dec;
    logic [2:0] m_led;
    logic       m_full, m_oe, m_ox;

    assign raw = {presence_exit, presence_entrance, presence_spot};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            n_run[i]  = (m_s2[i] == m_last[i]) ? ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]) : 1;
            n_last[i] = m_s2[i];
            n_deb[i]  = (m_s2[i] != m_deb[i] && n_run[i] >= D) ? m_s2[i] : m_deb[i];
        end
        inc     = (e_ph == 1 && !m_deb[3]) ? 1 : 0;
        dec     = (x_ph == 1 && !m_deb[4] && m_occ > 0) ? 1 : 0;
        n_occ   = m_occ + inc - dec;
        n_eph   = e_ph;
        n_eleft = e_left;
        if (e_ph == 0 && m_deb[3] && m_occ < 3) n_eph = 1;
        else if (e_ph == 1 && !m_deb[3]) begin
            n_eph   = 2;
            n_eleft = G - 1;
        end else if (e_ph == 2) begin
            if (m_deb[3] && m_occ < 3) n_eph = 1;
            else if (e_left == 0) n_eph = 0;
            else n_eleft = e_left - 1;
        end
        n_xph   = x_ph;
        n_xleft = x_left;
        if (x_ph == 0 && m_deb[4]) n_xph = 1;
        else if (x_ph == 1 && !m_deb[4]) begin
            n_xph   = 2;
            n_xleft = G - 1;
        end else if (x_ph == 2) begin
            if (m_deb[4]) n_xph = 1;
            else if (x_left == 0) n_xph = 0;
            else n_xleft = x_left - 1;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1   <= '0;
            m_s2   <= '0;
            m_last <= '0;
            m_deb  <= '0;
            for (int i = 0; i < 5; i++) m_run[i] <= 0;
            m_occ  <= 0;
            e_ph   <= 0;
            e_left <= 0;
            x_ph   <= 0;
            x_left <= 0;
            m_led  <= '0;
            m_full <= 1'b0;
            m_oe   <= 1'b0;
            m_ox   <= 1'b0;
        end else begin
            m_s1   <= raw;
            m_s2   <= m_s1;
            m_last <= n_last;
            m_deb  <= n_deb;
            for (int i = 0; i < 5; i++) m_run[i] <= n_run[i];
            m_occ  <= n_occ;
            e_ph   <= n_eph;
            e_left <= n_eleft;
            x_ph   <= n_xph;
            x_left <= n_xleft;
            m_led  <= m_deb[2:0];
            m_full <= m_occ == 3;
            m_oe   <= n_eph != 0;
            m_ox   <= n_xph != 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model led_spot", int'(led_spot), int'(m_led));
        chk("model led_full", int'(led_full), int'(m_full));
        chk("model open_entrance", int'(open_entrance), int'(m_oe));
        chk("model open_exit", int'(open_exit), int'(m_ox));
        chk("model occupancy", int'(occupancy), m_occ);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic car_enter();
        presence_entrance = 1'b1;
        step(12);
        presence_entrance = 1'b0;
        step(20);
    endtask

    task automatic car_exit();
        presence_exit = 1'b1;
        step(12);
        presence_exit = 1'b0;
        step(20);
    endtask

    initial begin
        step(3);
        chk("reset led_spot", int'(led_spot), 0);
        chk("reset led_full", int'(led_full), 0);
        chk("reset open_entrance", int'(open_entrance), 0);
        chk("reset open_exit", int'(open_exit), 0);
        chk("reset occupancy", int'(occupancy), 0);
        reset_n = 1'b1;
        step(5);
        // short glitch is filtered out
        presence_entrance = 1'b1;
        step(3);
        presence_entrance = 1'b0;
        step(15);
        chk("glitch open_entrance", int'(open_entrance), 0);
        chk("glitch occupancy", int'(occupancy), 0);
        // spot leds appear D+3 cycles after the raw change
        presence_spot = 3'b101;
        step(6);
        chk("spot early", int'(led_spot), 0);
        step(1);
        chk("spot on", int'(led_spot), 5);
        presence_spot = 3'b000;
        step(10);
        // single entry timing
        presence_entrance = 1'b1;
        step(6);
        chk("entry open early", int'(open_entrance), 0);
        step(1);
        chk("entry open", int'(open_entrance), 1);
        step(13);
        presence_entrance = 1'b0;
        step(6);
        chk("entry occ before fall", int'(occupancy), 0);
        step(1);
        chk("entry occ counted", int'(occupancy), 1);
        chk("entry hold open", int'(open_entrance), 1);
        step(7);
        chk("entry hold last", int'(open_entrance), 1);
        step(1);
        chk("entry closed", int'(open_entrance), 0);
        step(5);
        // fill and block
        car_enter();
        car_enter();
        chk("fill occupancy", int'(occupancy), 3);
        chk("fill led_full", int'(led_full), 1);
        presence_entrance = 1'b1;
        step(15);
        chk("blocked gate", int'(open_entrance), 0);
        presence_exit = 1'b1;
        step(12);
        presence_exit = 1'b0;
        step(7);
        chk("exit occ 2", int'(occupancy), 2);
        chk("waiting still closed", int'(open_entrance), 0);
        step(1);
        chk("waiting opens", int'(open_entrance), 1);
        chk("not full", int'(led_full), 0);
        presence_entrance = 1'b0;
        step(20);
        chk("refill occ", int'(occupancy), 3);
        car_exit();
        chk("back to 2", int'(occupancy), 2);
        // simultaneous entry and exit falling
        presence_entrance = 1'b1;
        presence_exit = 1'b1;
        step(12);
        presence_entrance = 1'b0;
        presence_exit = 1'b0;
        step(7);
        chk("simul occ", int'(occupancy), 2);
        step(20);
        chk("simul occ settled", int'(occupancy), 2);
        chk("simul ent closed", int'(open_entrance), 0);
        chk("simul exit closed", int'(open_exit), 0);
        // exit when empty
        car_exit();
        car_exit();
        chk("emptied", int'(occupancy), 0);
        presence_exit = 1'b1;
        step(7);
        chk("empty exit open", int'(open_exit), 1);
        step(5);
        presence_exit = 1'b0;
        step(7);
        chk("empty occ stays 0", int'(occupancy), 0);
        chk("empty exit holding", int'(open_exit), 1);
        step(9);
        chk("empty exit closed", int'(open_exit), 0);
        chk("empty occ final", int'(occupancy), 0);
        // reset while entrance is holding with two cars inside
        car_enter();
        presence_entrance = 1'b1;
        step(12);
        presence_entrance = 1'b0;
        step(8);
        chk("pre-reset occ", int'(occupancy), 2);
        chk("pre-reset open", int'(open_entrance), 1);
        reset_n = 1'b0;
        #1;
        chk("async reset occ", int'(occupancy), 0);
        chk("async reset open", int'(open_entrance), 0);
        chk("async reset full", int'(led_full), 0);
        step(1);
        reset_n = 1'b1;
        step(20);
        chk("post-reset occ", int'(occupancy), 0);
        chk("post-reset open", int'(open_entrance), 0);
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
